// File: rtl/id_pkg.sv
// Shared definitions for the decode stage and its downstream consumers.
// Contents: opcode constants, register-index width, the bit positions of
// the 152-bit idEx bundle, the control-field struct and the opcode decoder.
package id_pkg;

   localparam int REG_AW   = 5;
   localparam int BUNDLE_W = 152;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;

   // idEx bundle layout, used by ID, the ID/EX register and EX.
   localparam int RS_MSB      = 151;
   localparam int RS_LSB      = 147;
   localparam int PCINC_MSB   = 146;
   localparam int PCINC_LSB   = 115;
   localparam int RD1_MSB     = 114;
   localparam int RD1_LSB     = 83;
   localparam int RD2_MSB     = 82;
   localparam int RD2_LSB     = 51;
   localparam int IMM_MSB     = 50;
   localparam int IMM_LSB     = 19;
   localparam int RD_MSB      = 18;
   localparam int RD_LSB      = 14;
   localparam int RT_MSB      = 13;
   localparam int RT_LSB      = 9;
   localparam int CTRL_MSB    = 8;
   localparam int CTRL_LSB    = 0;
   localparam int MEMREAD_BIT = 5;

   // Field order matches bundle bits [8:0], MSB first.
   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       alu_src;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
      ctrl_t c;
      c = '0;
      case (opcode)
         OP_R: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.alu_op    = 2'b10;
         end
         OP_LW: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.mem_read   = 1'b1;
            c.alu_src    = 1'b1;
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.alu_op = 2'b01;
         end
         OP_ADDI: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Opcodes whose rt field is a source operand (not a load/immediate target).
   function automatic logic reads_rt(input logic [5:0] opcode);
      return (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Entry 0 is hard-wired to zero and never stored. A read that matches the
// address being written this cycle returns the write data (bypass), so WB
// results are visible to ID in the same cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears all entries)
//   ra1, ra2      read addresses
//   rd1, rd2      read data
//   we, wa, wd    write enable, write address, write data
module regfile_2r1w #(
   parameter int NREGS = 32,
   parameter int DW    = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);

   logic [DW-1:0] mem [1:NREGS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
      logic [DW-1:0] v;
      v = '0;
      if (ra != '0) begin
         if (we && (wa == ra)) v = wd;
         else                  v = mem[ra];
      end
      return v;
   endfunction

   assign rd1 = read_port(ra1);
   assign rd2 = read_port(ra2);

endmodule

// File: rtl/id_stage_pack.sv
// Decode stage: reads the register file, decodes the IF/ID instruction into
// WB/MEM/EXE control bits and packs the 152-bit idEx bundle. A one-entry
// hazard tracker remembers whether the previously emitted bundle was a load
// and its rt; a dependent instruction stalls for one cycle as a bubble.
// Ports:
//   clk, rst                          clock, async active-high reset
//   ifid_instr, ifid_pcinc, ifid_valid  IF/ID register contents
//   flush                             squash the current ID instruction
//   wb_regwrite, wb_rd, wb_data       register-file write port from WB
//   idEx                              bundle to ID/EX (combinational)
//   stall                             hold PC and IF/ID this cycle
module id_stage_pack
   import id_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int DW    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         ifid_instr,
   input  logic [DW-1:0]       ifid_pcinc,
   input  logic                ifid_valid,
   input  logic                flush,
   input  logic                wb_regwrite,
   input  logic [REG_AW-1:0]   wb_rd,
   input  logic [DW-1:0]       wb_data,
   output logic [BUNDLE_W-1:0] idEx,
   output logic                stall
);

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;
   logic [DW-1:0]     read1;
   logic [DW-1:0]     read2;
   logic [DW-1:0]     sext;
   ctrl_t             ctrl;
   logic              bubble;
   logic              prev_memread;
   logic [REG_AW-1:0] prev_rt;

   assign opcode = ifid_instr[31:26];
   assign rs     = ifid_instr[25:21];
   assign rt     = ifid_instr[20:16];
   assign rd     = ifid_instr[15:11];
   assign sext   = {{(DW-16){ifid_instr[15]}}, ifid_instr[15:0]};
   assign ctrl   = decode_ctrl(opcode);

   regfile_2r1w #(
      .NREGS (NREGS),
      .DW    (DW),
      .AW    (REG_AW)
   ) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (read1),
      .rd2 (read2),
      .we  (wb_regwrite),
      .wa  (wb_rd),
      .wd  (wb_data)
   );

   // r0 is never a real load target, so a load into r0 cannot create a hazard.
   assign stall = ifid_valid && !flush && prev_memread && (prev_rt != '0) &&
                  ((prev_rt == rs) || ((prev_rt == rt) && reads_rt(opcode)));

   assign bubble = flush || stall || !ifid_valid;

   always_comb begin
      idEx                      = '0;
      idEx[RS_MSB:RS_LSB]       = rs;
      idEx[PCINC_MSB:PCINC_LSB] = ifid_pcinc;
      idEx[RD1_MSB:RD1_LSB]     = read1;
      idEx[RD2_MSB:RD2_LSB]     = read2;
      idEx[IMM_MSB:IMM_LSB]     = sext;
      idEx[RD_MSB:RD_LSB]       = rd;
      idEx[RT_MSB:RT_LSB]       = rt;
      idEx[CTRL_MSB:CTRL_LSB]   = bubble ? '0 : ctrl;
   end

   // Tracking the emitted bundle (not the raw decode) means a bubble clears
   // the load flag, so each load-use pair costs exactly one stall cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_memread <= 1'b0;
         prev_rt      <= '0;
      end else begin
         prev_memread <= idEx[MEMREAD_BIT];
         prev_rt      <= idEx[RT_MSB:RT_LSB];
      end
   end

endmodule

// File: tb/tb_id_stage_pack.sv
module tb_id_stage_pack;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  ifid_instr;
   logic [31:0]  ifid_pcinc;
   logic         ifid_valid;
   logic         flush;
   logic         wb_regwrite;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data;
   logic [151:0] idEx;
   logic         stall;

   int total = 0;
   int bad   = 0;

   id_stage_pack dut (
      .clk         (clk),
      .rst         (rst),
      .ifid_instr  (ifid_instr),
      .ifid_pcinc  (ifid_pcinc),
      .ifid_valid  (ifid_valid),
      .flush       (flush),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .idEx        (idEx),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0]  m_regs [32];
   logic         m_last_was_load;
   logic [4:0]   m_last_rt;
   logic [151:0] m_want;
   logic         m_want_stall;

   task automatic check_val(input string tag, input logic [151:0] obs, input logic [151:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   function automatic logic [8:0] ctrl_of(input logic [5:0] op);
      case (op)
         6'h00:   return 9'b10_000_1_10_0;
         6'h23:   return 9'b11_010_0_00_1;
         6'h2B:   return 9'b00_001_0_00_1;
         6'h04:   return 9'b00_100_0_01_0;
         6'h08:   return 9'b10_000_0_00_1;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] reg_read(input logic [4:0] r);
      if (r == 0) return 32'h0;
      if (wb_regwrite && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic logic [31:0] rtype(input int s, input int t, input int d);
      return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int s, input int t,
                                          input logic [15:0] imm);
      return {op, 5'(s), 5'(t), imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_last_was_load = 1'b0;
      m_last_rt       = 5'd0;
   endtask

   task automatic model_check();
      logic [5:0] op;
      logic [4:0] s, t, d;
      logic       uses_t;
      op = ifid_instr[31:26];
      s  = ifid_instr[25:21];
      t  = ifid_instr[20:16];
      d  = ifid_instr[15:11];
      uses_t = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      m_want_stall = ifid_valid && !flush && m_last_was_load && (m_last_rt != 0) &&
                     ((m_last_rt == s) || (uses_t && m_last_rt == t));
      m_want = {s, ifid_pcinc, reg_read(s), reg_read(t),
                {{16{ifid_instr[15]}}, ifid_instr[15:0]}, d, t,
                (flush || m_want_stall || !ifid_valid) ? 9'b0 : ctrl_of(op)};
      check_val("stall", {151'b0, stall}, {151'b0, m_want_stall});
      check_val("idEx", idEx, m_want);
   endtask

   task automatic model_clock();
      if (wb_regwrite && wb_rd != 0) m_regs[wb_rd] = wb_data;
      m_last_was_load = m_want[5];
      m_last_rt       = m_want[13:9];
   endtask

   task automatic cycle(input logic [31:0] instr, input logic valid, input logic fl,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
      @(negedge clk);
      ifid_instr  = instr;
      ifid_pcinc  = $urandom;
      ifid_valid  = valid;
      flush       = fl;
      wb_regwrite = we;
      wb_rd       = wrd;
      wb_data     = wdat;
      #1;
      model_check();
      @(posedge clk);
      model_clock();
   endtask

   initial begin
      rst = 1'b1;
      ifid_instr = rtype(1, 2, 3);
      ifid_pcinc = 32'h4;
      ifid_valid = 1'b1;
      flush = 1'b0;
      wb_regwrite = 1'b0;
      wb_rd = 5'd0;
      wb_data = 32'h0;
      model_reset();
      #2;
      check_val("rst_stall", {151'b0, stall}, 152'd0);
      check_val("rst_ctrl", {143'b0, idEx[8:0]}, {143'b0, 9'b10_000_1_10_0});
      @(negedge clk);
      rst = 1'b0;

      // 1: preload r1=5, r2=7 then add $3,$1,$2
      cycle(32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
      cycle(32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
      cycle(rtype(1, 2, 3), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t1_read1", {120'b0, idEx[114:83]}, 152'd5);
      check_val("t1_read2", {120'b0, idEx[82:51]}, 152'd7);
      check_val("t1_rd", {147'b0, idEx[18:14]}, 152'd3);
      check_val("t1_ctrl", {143'b0, idEx[8:0]}, {143'b0, 9'b10_000_1100});

      // 2: lw $4,8($1) ; add $5,$4,$2 -> one stall, then re-issue
      cycle(itype(6'h23, 1, 4, 16'd8), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t2_lw_ctrl", {143'b0, idEx[8:0]}, {143'b0, 9'b11_010_0001});
      cycle(rtype(4, 2, 5), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t2_stall", {151'b0, stall}, 152'd1);
      check_val("t2_bubble", {143'b0, idEx[8:0]}, 152'd0);
      cycle(rtype(4, 2, 5), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t2_release", {151'b0, stall}, 152'd0);
      check_val("t2_reissue", {143'b0, idEx[8:0]}, {143'b0, 9'b10_000_1100});

      // 3: load into r0 never stalls
      cycle(itype(6'h23, 1, 0, 16'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      cycle(rtype(0, 2, 5), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t3_r0_stall", {151'b0, stall}, 152'd0);

      // 4: WB bypass and r0 write protection
      cycle(rtype(6, 0, 7), 1'b1, 1'b0, 1'b1, 5'd6, 32'hDEADBEEF);
      check_val("t4_bypass", {120'b0, idEx[114:83]}, {120'b0, 32'hDEADBEEF});
      cycle(rtype(6, 0, 7), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t4_stored", {120'b0, idEx[114:83]}, {120'b0, 32'hDEADBEEF});
      cycle(rtype(0, 0, 7), 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
      check_val("t4_r0_bypass", {120'b0, idEx[114:83]}, 152'd0);
      cycle(rtype(0, 0, 7), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t4_r0_stored", {120'b0, idEx[114:83]}, 152'd0);

      // 5: flush wins over load-use; beq sign extension
      cycle(itype(6'h23, 1, 4, 16'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      cycle(rtype(4, 2, 5), 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      check_val("t5_flush_stall", {151'b0, stall}, 152'd0);
      check_val("t5_flush_ctrl", {143'b0, idEx[8:0]}, 152'd0);
      cycle(itype(6'h04, 1, 2, 16'hFFFC), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t5_beq_imm", {120'b0, idEx[50:19]}, {120'b0, 32'hFFFFFFFC});
      check_val("t5_beq_ctrl", {143'b0, idEx[8:0]}, {143'b0, 9'b00_100_0_01_0});

      // 6: async reset during a stall
      cycle(itype(6'h23, 1, 4, 16'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      ifid_instr = rtype(4, 2, 5);
      #1;
      model_check();
      check_val("t6_pre_stall", {151'b0, stall}, 152'd1);
      #1 rst = 1'b1;
      #1;
      check_val("t6_async_drop", {151'b0, stall}, 152'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(rtype(1, 2, 3), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check_val("t6_read1_zero", {120'b0, idEx[114:83]}, 152'd0);
      check_val("t6_read2_zero", {120'b0, idEx[82:51]}, 152'd0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [5:0]  op;
         logic [31:0] ins;
         case ($urandom_range(0, 5))
            0:       op = 6'h00;
            1:       op = 6'h23;
            2:       op = 6'h2B;
            3:       op = 6'h04;
            4:       op = 6'h08;
            default: op = 6'($urandom);
         endcase
         ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         cycle(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
               1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
